// File: rtl/find_max_feeder.sv
// find_max_feeder: upstream stage of find_MAX.
// Collects 5-byte operand records (instruction, A, B, C, select) from a
// byte-serial valid/ready stream into a small buffer. A go pulse replays the
// batch as one start cycle followed by back-to-back valid beats on registered
// outputs that wire straight into find_MAX.
// Optional feature macro: FEEDER_REPLAY_EN. It adds a replay input that
// re-issues the last completed batch.

module find_max_feeder #(
    parameter int DEPTH = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       go,
`ifdef FEEDER_REPLAY_EN
    input  logic       replay,
`endif
    output logic       busy,
    output logic       done,
    output logic       start,
    output logic       valid,
    output logic [7:0] data_A,
    output logic [7:0] data_B,
    output logic [7:0] data_C,
    output logic [7:0] instruction,
    output logic [2:0] count,
    output logic [2:0] select
);

    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    logic [1:0] state;
    logic [2:0] byte_cnt;
    logic [2:0] rec_cnt;
    logic [2:0] idx;

    logic [7:0] mem_instr [DEPTH];
    logic [7:0] mem_a     [DEPTH];
    logic [7:0] mem_b     [DEPTH];
    logic [7:0] mem_c     [DEPTH];
    logic [2:0] mem_sel   [DEPTH];

    logic       full;
    logic       go_ok;
    logic       replay_ok;
    logic       launch;
    logic       accept;
    logic [2:0] launch_cnt;
    logic [2:0] rd_idx;

    // Full only at a record boundary, so a partially received record can
    // always be finished.
    assign full   = (byte_cnt == 3'd0) && (rec_cnt == DEPTH_C);
    assign go_ok  = (state == LOAD) && go && (rec_cnt != 3'd0) && (byte_cnt == 3'd0);

`ifdef FEEDER_REPLAY_EN
    logic [2:0] last_cnt;

    assign replay_ok  = (state == LOAD) && replay && (rec_cnt == 3'd0) &&
                        (byte_cnt == 3'd0) && (last_cnt != 3'd0);
    assign launch_cnt = go_ok ? rec_cnt : last_cnt;
`else
    assign replay_ok  = 1'b0;
    assign launch_cnt = rec_cnt;
`endif

    assign launch = go_ok || replay_ok;

    // A pending go (or an accepted replay) wins over an incoming byte; the
    // source has to hold the byte until LOAD comes back.
    assign in_ready = rst_n && (state == LOAD) && !go && !replay_ok && !full;
    assign accept   = in_valid && in_ready;

    assign busy  = (state != LOAD);
    assign start = (state == START);
    assign done  = (state == DONE);

    // START reads entry 0; every ISSUE cycle reads the next entry in order.
    assign rd_idx = (state == START) ? 3'd0 : idx;

    // Record bytes land directly in the entry being filled; no reset needed
    // because rec_cnt decides what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            case (byte_cnt)
                3'd0:    mem_instr[rec_cnt] <= in_data;
                3'd1:    mem_a[rec_cnt]     <= in_data;
                3'd2:    mem_b[rec_cnt]     <= in_data;
                3'd3:    mem_c[rec_cnt]     <= in_data;
                default: mem_sel[rec_cnt]   <= in_data[2:0];
            endcase
        end
    end

    // Batch sequencer: LOAD -> START -> ISSUE (count beats) -> DONE -> LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            byte_cnt    <= 3'd0;
            rec_cnt     <= 3'd0;
            idx         <= 3'd0;
            valid       <= 1'b0;
            data_A      <= 8'd0;
            data_B      <= 8'd0;
            data_C      <= 8'd0;
            instruction <= 8'd0;
            select      <= 3'd0;
            count       <= 3'd0;
`ifdef FEEDER_REPLAY_EN
            last_cnt    <= 3'd0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    if (launch) begin
                        state <= START;
                        count <= launch_cnt;
                        idx   <= 3'd0;
`ifdef FEEDER_REPLAY_EN
                        if (go_ok) begin
                            last_cnt <= rec_cnt;
                        end
`endif
                    end else if (accept) begin
                        if (byte_cnt == 3'd4) begin
                            byte_cnt <= 3'd0;
                            rec_cnt  <= rec_cnt + 3'd1;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                end
                START: begin
                    state       <= ISSUE;
                    valid       <= 1'b1;
                    data_A      <= mem_a[rd_idx];
                    data_B      <= mem_b[rd_idx];
                    data_C      <= mem_c[rd_idx];
                    instruction <= mem_instr[rd_idx];
                    select      <= mem_sel[rd_idx];
                    idx         <= 3'd1;
                end
                ISSUE: begin
                    if (idx == count) begin
                        state       <= DONE;
                        valid       <= 1'b0;
                        data_A      <= 8'd0;
                        data_B      <= 8'd0;
                        data_C      <= 8'd0;
                        instruction <= 8'd0;
                        select      <= 3'd0;
                    end else begin
                        data_A      <= mem_a[rd_idx];
                        data_B      <= mem_b[rd_idx];
                        data_C      <= mem_c[rd_idx];
                        instruction <= mem_instr[rd_idx];
                        select      <= mem_sel[rd_idx];
                        idx         <= idx + 3'd1;
                    end
                end
                default: begin
                    state    <= LOAD;
                    count    <= 3'd0;
                    rec_cnt  <= 3'd0;
                    byte_cnt <= 3'd0;
                    idx      <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_find_max_feeder.sv
// Testbench for find_max_feeder. Records loaded into the DUT are queued as
// expected beats when go/replay is driven; a negedge monitor pops and
// compares them whenever valid is high. Define FEEDER_REPLAY_EN for both
// the DUT and this bench to exercise replay.

module tb_find_max_feeder;

    typedef logic [39:0] rec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       go = 1'b0;
`ifdef FEEDER_REPLAY_EN
    logic       replay = 1'b0;
`endif
    logic       in_ready, busy, done, start, valid;
    logic [7:0] data_A, data_B, data_C, instruction;
    logic [2:0] count, select;

    int checks = 0;
    int errors = 0;

    rec_t loaded[$];
    rec_t exp_q[$];
    rec_t last_batch[$];

    find_max_feeder #(.DEPTH(7)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .go(go),
`ifdef FEEDER_REPLAY_EN
        .replay(replay),
`endif
        .busy(busy),
        .done(done),
        .start(start),
        .valid(valid),
        .data_A(data_A),
        .data_B(data_B),
        .data_C(data_C),
        .instruction(instruction),
        .count(count),
        .select(select)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Scoreboard side: every valid beat must match the oldest queued record.
    always @(negedge clk) begin
        rec_t r;
        if (rst_n) begin
            if (valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("extra_beat", 32'd1, 32'd0);
                end else begin
                    r = exp_q.pop_front();
                    checkOutput("beat_instr", 32'(instruction), 32'(r[39:32]));
                    checkOutput("beat_A", 32'(data_A), 32'(r[31:24]));
                    checkOutput("beat_B", 32'(data_B), 32'(r[23:16]));
                    checkOutput("beat_C", 32'(data_C), 32'(r[15:8]));
                    checkOutput("beat_sel", 32'(select), 32'(r[2:0]));
                end
            end else begin
                checkOutput("idle_data", {data_A, data_B, data_C, instruction}, 32'd0);
                checkOutput("idle_sel", 32'(select), 32'd0);
            end
        end
    end

    // Drives one byte and waits (bounded) until it is taken.
    task automatic sendByte(input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int n = 0; n < 100; n++) begin
            acc = in_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc) break;
        end
        if (!acc) checkOutput("byte_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic sendRecord(input rec_t r);
        sendByte(r[39:32]);
        sendByte(r[31:24]);
        sendByte(r[23:16]);
        sendByte(r[15:8]);
        sendByte(r[7:0]);
        loaded.push_back(r);
    endtask

    task automatic pulseGo();
        go = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic launchBatch();
        foreach (loaded[i]) exp_q.push_back(loaded[i]);
        last_batch = loaded;
        loaded.delete();
        pulseGo();
    endtask

    // Called at the negedge of the START cycle; ends at the first LOAD cycle.
    task automatic checkBatch(input int n);
        checkOutput("start_hi", 32'(start), 32'd1);
        checkOutput("start_valid_lo", 32'(valid), 32'd0);
        checkOutput("start_count", 32'(count), 32'(n));
        checkOutput("start_busy", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("issue_valid", 32'(valid), 32'd1);
            checkOutput("issue_start_lo", 32'(start), 32'd0);
            checkOutput("issue_count", 32'(count), 32'(n));
        end
        @(negedge clk);
        checkOutput("done_hi", 32'(done), 32'd1);
        checkOutput("done_valid_lo", 32'(valid), 32'd0);
        checkOutput("done_count", 32'(count), 32'(n));
        checkOutput("done_busy", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("load_done_lo", 32'(done), 32'd0);
        checkOutput("load_busy_lo", 32'(busy), 32'd0);
        checkOutput("load_count_zero", 32'(count), 32'd0);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic expectNoStart(input string tag);
        checkOutput({tag, "_start"}, 32'(start), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_start2"}, 32'(start), 32'd0);
    endtask

    task automatic applyStimulus();
        rec_t r;
        // Reset state
        #1;
        checkOutput("reset_outputs",
                    {start, valid, done, busy, in_ready, count, select, 20'd0}, 32'd0);
        checkOutput("reset_data", {data_A, data_B, data_C, instruction}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_after_reset", 32'(in_ready), 32'd1);

        // Two-record batch
        sendRecord(40'h08_05_09_03_01);
        sendRecord(40'h10_FF_00_7F_06);
        launchBatch();
        checkBatch(2);

`ifdef FEEDER_REPLAY_EN
        foreach (last_batch[i]) exp_q.push_back(last_batch[i]);
        replay = 1'b1;
        @(posedge clk);
        @(negedge clk);
        replay = 1'b0;
        checkBatch(2);
        sendByte(8'h21);
        replay = 1'b1;
        @(posedge clk);
        @(negedge clk);
        replay = 1'b0;
        expectNoStart("replay_ignored");
        sendByte(8'h22);
        sendByte(8'h23);
        sendByte(8'h24);
        sendByte(8'hFD);
        loaded.push_back(40'h21_22_23_24_FD);
        launchBatch();
        checkBatch(1);
`endif

        // Full buffer: seven records, select upper bits are junk
        for (int i = 0; i < 7; i++) begin
            r = {8'($urandom), 32'($urandom)};
            sendRecord(r);
        end
        checkOutput("ready_full", 32'(in_ready), 32'd0);
        launchBatch();
        checkBatch(7);

        // go in the middle of a record is ignored
        sendByte(8'h31);
        sendByte(8'h32);
        sendByte(8'h33);
        pulseGo();
        expectNoStart("go_partial");
        sendByte(8'h34);
        sendByte(8'hFB);
        loaded.push_back(40'h31_32_33_34_FB);
        launchBatch();
        checkBatch(1);

        // go together with a byte at a record boundary
        sendRecord(40'h41_42_43_44_02);
        foreach (loaded[i]) exp_q.push_back(loaded[i]);
        loaded.delete();
        go       = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h51;
        #1;
        checkOutput("ready_blocked_by_go", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        checkBatch(1);
        checkOutput("ready_after_done", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        sendByte(8'h52);
        sendByte(8'h53);
        sendByte(8'h54);
        sendByte(8'h05);
        loaded.push_back(40'h51_52_53_54_05);
        launchBatch();
        checkBatch(1);

        // Reset during the second beat of a four-record batch
        for (int i = 0; i < 4; i++) begin
            r = {8'($urandom), 32'($urandom)};
            sendRecord(r);
        end
        launchBatch();
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ctrl", {29'd0, start, valid, done}, 32'd0);
        checkOutput("abort_busy_ready", {30'd0, busy, in_ready}, 32'd0);
        checkOutput("abort_count_sel", {26'd0, count, select}, 32'd0);
        checkOutput("abort_data", {data_A, data_B, data_C, instruction}, 32'd0);
        exp_q.delete();
        loaded.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_after_abort", 32'(in_ready), 32'd1);
        @(negedge clk);
        pulseGo();
        expectNoStart("go_empty");
    endtask

    initial begin
        applyStimulus();
        checkOutput("queue_empty_end", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/find_max_feeder.md
Name: find_max_feeder

Overview:
- Upstream stage of find_MAX.
- Accepts operand records as a byte-serial valid/ready stream and buffers up to DEPTH records.
- On a `go` pulse, replays the buffered batch as one start cycle followed by back-to-back valid beats, driving data_A/B/C, instruction, select and count directly into find_MAX.
- Outputs are registered and connect straight to find_MAX inputs with no glue logic.

Parameters:
- DEPTH, 7, maximum records per batch; legal range 1..7 (count is 3 bits).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  byte present on in_data.
- in_data  input  8  record byte stream.
- in_ready  output  1  byte accepted when in_valid && in_ready.
- go  input  1  single-cycle request to issue the buffered batch.
- busy  output  1  high in START, ISSUE, DONE.
- done  output  1  one-cycle pulse after the last beat.
- start  output  1  to find_MAX.start.
- valid  output  1  to find_MAX.valid.
- data_A  output  8  to find_MAX.data_A.
- data_B  output  8  to find_MAX.data_B.
- data_C  output  8  to find_MAX.data_C.
- instruction  output  8  to find_MAX.instruction.
- count  output  3  to find_MAX.count; number of beats in the batch.
- select  output  3  to find_MAX.select.

Behaviour:
- Reset: rst_n low asynchronously forces the following; in_ready is also 0 while rst_n is low.
  - state = LOAD
  - byte_cnt = 0, rec_cnt = 0, issue index = 0
  - all outputs 0
- Record format: 5 bytes in order instruction, A, B, C, select byte. Only bits [2:0] of the select byte are used; bits [7:3] are ignored.
- Buffer: DEPTH x 36 bits (8+8+8+8+3+1 spare allowed).
  - A record commits when byte 4 is accepted: byte_cnt wraps 4->0 and rec_cnt increments.
- in_ready = (state == LOAD) && !go && !(byte_cnt == 0 && rec_cnt == DEPTH).
  - The buffer is full only at a record boundary, so a partial record can always be completed.
- LOAD state:
  - go is accepted only if rec_cnt > 0 and byte_cnt == 0; otherwise it is ignored, with no state change and no error.
  - go has priority over a simultaneous byte: in_ready is low that cycle, so the byte is not consumed and the source must hold it.
  - Accepted go at cycle T -> START at T+1.
- START (1 cycle): start = 1, valid = 0, count = rec_cnt, data outputs 0.
- ISSUE (rec_cnt cycles, T+2 .. T+1+rec_cnt):
  - valid = 1 every cycle; data_A/B/C, instruction, select come from entry 0, 1, ... in load order.
  - count is held at the batch size.
  - No gaps and no back-pressure.
- DONE (1 cycle): done = 1; valid, start and data outputs = 0; count holds.
  - Next cycle: LOAD, with rec_cnt = 0, byte_cnt = 0 and count = 0.
- Outside ISSUE, valid = 0 and the data outputs are 0. start is high only in START.
- in_valid is ignored outside LOAD.
- Reset mid-batch aborts immediately: all outputs 0 and buffered records are discarded.
- A partial record persists across idle cycles indefinitely; there is no timeout.

Optional Feature:
- Macro: FEEDER_REPLAY_EN.
- With the macro defined:
  - Adds input port `replay` (1 bit).
  - Buffer contents and the last batch size (last_cnt, reset 0) are retained after DONE.
  - In LOAD with rec_cnt == 0, byte_cnt == 0 and last_cnt > 0, a replay pulse issues the stored last_cnt entries with timing identical to go.
  - replay is ignored in all other conditions, including whenever rec_cnt > 0.
  - Loading a new record overwrites entries from index 0, and last_cnt updates at the next go.
- Without the macro: no replay port, last_cnt is not implemented, and the buffer is logically empty after DONE.

Test Plan:
- Load 2 records {08,05,09,03,01} and {10,FF,00,7F,06}, then pulse go -> start at T+1 with count = 2, then valid beats at T+2 (A=05, B=09, C=03, instr=08, sel=1) and T+3 (A=FF, B=00, C=7F, instr=10, sel=6), done at T+4, busy high T+1..T+4.
- Load 7 records with DEPTH = 7 -> in_ready drops after the 35th byte; go then yields 7 valid beats with count = 7.
- Pulse go after 3 bytes of the first record -> ignored, no start; finish the record, pulse go -> count = 1, one beat.
- Assert go together with an in_valid byte at a boundary with rec_cnt = 1 -> the byte is not accepted and the batch issues 1 beat; the held byte is accepted in LOAD after done.
- Pull rst_n low during the 2nd ISSUE beat of a 4-record batch -> all outputs 0 immediately; a go after reset with no loaded records produces no start.
- With FEEDER_REPLAY_EN: after the scenario 1 batch completes, pulse replay -> the identical 2-beat sequence repeats; a replay sent after a new byte has been loaded is ignored.
